// File: rtl/axis_throttle_fifo.sv
// AXI-Stream FIFO buffer with a programmable slave-side ready throttle,
// plus fill-level and completed-packet counters for debug.
module axis_throttle_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int THR_ON  = 3,
  parameter int THR_OFF = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic                     s_last_i,
  output logic [DATA_W-1:0]        m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic                     m_last_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              pkt_cnt_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int PERIOD = THR_ON + THR_OFF;
  localparam int TC_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [DATA_W:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]   wp_q, wp_d;
  logic [PTR_W-1:0]   rp_q, rp_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [TC_W-1:0]    tc_q, tc_d;
  logic [15:0]        pktCnt_q, pktCnt_d;

  logic               full;
  logic               empty;
  logic               windowOpen;
  logic               sReady;
  logic               push;
  logic               pop;
  logic [DATA_W:0]    rdEntry;

  assign full       = (level_q == LVL_W'(DEPTH));
  assign empty      = (level_q == '0);
  assign windowOpen = (THR_OFF == 0) || (tc_q < TC_W'(THR_ON));
  // No pass-through when full: a same-cycle pop never frees room for a push.
  assign sReady     = !rst && !full && windowOpen;
  assign push       = s_valid_i && sReady;
  assign pop        = !empty && m_ready_i;
  assign rdEntry    = mem_q[rp_q];

  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    level_d  = level_q;
    pktCnt_d = pktCnt_q;
    tc_d     = (tc_q == TC_W'(PERIOD - 1)) ? '0 : tc_q + TC_W'(1);
    if (push) begin
      wp_d = wp_q + PTR_W'(1);
    end
    if (pop) begin
      rp_d = rp_q + PTR_W'(1);
      if (rdEntry[DATA_W]) begin
        pktCnt_d = pktCnt_q + 16'd1;
      end
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q     <= '0;
      rp_q     <= '0;
      level_q  <= '0;
      tc_q     <= '0;
      pktCnt_q <= '0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      level_q  <= level_d;
      tc_q     <= tc_d;
      pktCnt_q <= pktCnt_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= {s_last_i, s_data_i};
    end
  end

  always_comb begin
    s_ready_o = sReady;
    m_valid_o = !empty;
    m_data_o  = empty ? '0 : rdEntry[DATA_W-1:0];
    m_last_o  = empty ? 1'b0 : rdEntry[DATA_W];
    level_o   = level_q;
    pkt_cnt_o = pktCnt_q;
  end

endmodule

// File: tb/tb_axis_throttle_fifo.sv
// Scoreboard bench: one unthrottled FIFO for ordering/backpressure/reset,
// one throttled FIFO for the ready-window pattern.
module tb_axis_throttle_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  s_data0 = '0;
  logic        s_valid0 = 1'b0;
  logic        s_last0 = 1'b0;
  logic        s_ready0;
  logic [7:0]  m_data0;
  logic        m_valid0;
  logic        m_ready0 = 1'b0;
  logic        m_last0;
  logic [2:0]  level0;
  logic [15:0] pkt0;

  logic [7:0]  s_data1 = '0;
  logic        s_valid1 = 1'b0;
  logic        s_last1 = 1'b0;
  logic        s_ready1;
  logic [7:0]  m_data1;
  logic        m_valid1;
  logic        m_ready1 = 1'b0;
  logic        m_last1;
  logic [2:0]  level1;
  logic [15:0] pkt1;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  int          pktExp = 0;
  int          maxLevel = 0;

  always #5 clk = ~clk;

  axis_throttle_fifo #(.DATA_W(8), .DEPTH(4), .THR_ON(3), .THR_OFF(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_data_i(s_data0), .s_valid_i(s_valid0), .s_ready_o(s_ready0), .s_last_i(s_last0),
    .m_data_o(m_data0), .m_valid_o(m_valid0), .m_ready_i(m_ready0), .m_last_o(m_last0),
    .level_o(level0), .pkt_cnt_o(pkt0)
  );

  axis_throttle_fifo #(.DATA_W(8), .DEPTH(4), .THR_ON(3), .THR_OFF(2)) dut1 (
    .clk(clk), .rst(rst),
    .s_data_i(s_data1), .s_valid_i(s_valid1), .s_ready_o(s_ready1), .s_last_i(s_last1),
    .m_data_o(m_data1), .m_valid_o(m_valid1), .m_ready_i(m_ready1), .m_last_o(m_last1),
    .level_o(level1), .pkt_cnt_o(pkt1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Model of the unthrottled FIFO: queue size is the expected level.
  always @(negedge clk) begin
    logic [8:0] expWord;
    if (!rst) begin
      checkOutput("level", 32'(level0), 32'(q0.size()));
      checkOutput("m_valid", 32'(m_valid0), 32'(q0.size() != 0));
      checkOutput("s_ready", 32'(s_ready0), 32'(q0.size() != 4));
      checkOutput("pkt_cnt", 32'(pkt0), 32'(pktExp));
      if (q0.size() == 0) begin
        checkOutput("m_idle", 32'({m_last0, m_data0}), 32'd0);
      end else if (m_ready0) begin
        expWord = q0.pop_front();
        checkOutput("m_word", 32'({m_last0, m_data0}), 32'(expWord));
        if (expWord[8]) pktExp++;
      end
      if (s_valid0 && s_ready0) q0.push_back({s_last0, s_data0});
      if (int'(level0) > maxLevel) maxLevel = int'(level0);
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic l);
    bit acc = 0;
    s_data0 = d;
    s_last0 = l;
    s_valid0 = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (s_ready0) acc = 1;
      @(posedge clk); #1;
    end
    s_valid0 = 1'b0;
    s_last0 = 1'b0;
    if (!acc) checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drainFifo();
    bit done = 0;
    m_ready0 = 1'b1;
    for (int t = 0; t < 30 && !done; t++) begin
      @(negedge clk);
      if (level0 == 0 && q0.size() == 0) done = 1;
      @(posedge clk); #1;
    end
    if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    pktExp = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int accepted;
    int popped;
    bit randDone;
    logic [8:0] w;
    logic [7:0] d1;
    bit pushedNow;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_level", 32'(level0), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid0), 32'd0);
    checkOutput("rst_m_data", 32'({m_last0, m_data0}), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready0), 32'd0);
    checkOutput("rst_pkt", 32'(pkt0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic three-word packet with sink always ready
    m_ready0 = 1'b1;
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b1);
    drainFifo();
    @(negedge clk);
    checkOutput("pkt_after_first", 32'(pkt0), 32'd1);

    // Fill against a stalled sink, then pop while full with source still valid
    @(posedge clk); #1;
    m_ready0 = 1'b0;
    s_valid0 = 1'b1;
    s_data0 = 8'hA0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pushedNow = s_ready0;
      if (pushedNow) accepted++;
      @(posedge clk); #1;
      if (pushedNow) s_data0 = s_data0 + 8'd1;
    end
    @(negedge clk);
    checkOutput("fill_accepted", 32'(accepted), 32'd4);
    checkOutput("full_level", 32'(level0), 32'd4);
    checkOutput("full_s_ready", 32'(s_ready0), 32'd0);
    @(posedge clk); #1;
    m_ready0 = 1'b1;
    @(posedge clk); #1;
    m_ready0 = 1'b0;
    @(negedge clk);
    checkOutput("after_pop_level", 32'(level0), 32'd3);
    checkOutput("after_pop_s_ready", 32'(s_ready0), 32'd1);
    @(posedge clk); #1;
    s_valid0 = 1'b0;
    drainFifo();

    // Ten words with a randomly stalling sink; wraps both pointers
    randDone = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) applyStimulus(8'(k), (k % 3) == 2);
        randDone = 1;
      end
      begin
        while (!randDone) begin
          @(posedge clk); #1;
          m_ready0 = 1'($urandom_range(0, 1));
        end
      end
    join
    drainFifo();
    checkOutput("max_level", 32'(maxLevel <= 4), 32'd1);
    applyStimulus(8'h55, 1'b1);
    drainFifo();

    // Two entries in flight and five packets, then a one-cycle reset
    m_ready0 = 1'b0;
    applyStimulus(8'hC1, 1'b0);
    applyStimulus(8'hC2, 1'b1);
    @(negedge clk);
    checkOutput("pre_rst_level", 32'(level0), 32'd2);
    checkOutput("pre_rst_pkt", 32'(pkt0), 32'd5);
    @(posedge clk); #1;
    pulseReset();
    @(negedge clk);
    checkOutput("post_rst_level", 32'(level0), 32'd0);
    checkOutput("post_rst_m_valid", 32'(m_valid0), 32'd0);
    checkOutput("post_rst_m_data", 32'(m_data0), 32'd0);
    checkOutput("post_rst_pkt", 32'(pkt0), 32'd0);
    checkOutput("post_rst_s_ready", 32'(s_ready0), 32'd1);
    m_ready0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    m_ready0 = 1'b0;

    // Throttled instance: 1,1,1,0,0 window from the first cycle after reset
    pulseReset();
    s_valid1 = 1'b1;
    m_ready1 = 1'b1;
    d1 = 8'd0;
    s_data1 = d1;
    accepted = 0;
    popped = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("thr_s_ready_%0d", i), 32'(s_ready1), 32'((i % 5) < 3));
      pushedNow = s_valid1 && s_ready1;
      if (m_valid1 && m_ready1) begin
        if (q1.size() == 0) begin
          checkOutput("thr_unexpected_out", 32'(m_data1), 32'hFFFF_FFFF);
        end else begin
          w = q1.pop_front();
          checkOutput("thr_word", 32'({m_last1, m_data1}), 32'(w));
        end
        popped++;
      end
      if (pushedNow) begin
        q1.push_back({s_last1, s_data1});
        accepted++;
      end
      @(posedge clk); #1;
      if (pushedNow) begin
        d1 = d1 + 8'd1;
        s_data1 = d1;
      end
    end
    checkOutput("thr_accepted", 32'(accepted), 32'd12);
    checkOutput("thr_popped", 32'(popped), 32'd12);
    s_valid1 = 1'b0;
    m_ready1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
